// File: rtl/patch_readout_ctrl_if.sv
// Patch-bank read port and element stream shared by the readout controller and its neighbours.
// Stream handshake: a beat transfers on a cycle where out_valid && out_ready; out_* hold while stalled.
interface patch_readout_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int NUM_PU = 28,
  parameter int ROUNDS = 28
);
  localparam int PU_W  = $clog2(NUM_PU);
  localparam int IDX_W = $clog2(K * K);
  localparam int RND_W = $clog2(ROUNDS);

  logic              rd_en;
  logic [PU_W-1:0]   rd_pu;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PU_W-1:0]   out_pu;
  logic              out_last;
  logic [RND_W-1:0]  out_round;

  modport master (
    output rd_en, rd_pu, rd_idx,
    input  rd_data,
    output out_valid, out_data, out_pu, out_last, out_round,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_pu, rd_idx,
    output rd_data,
    input  out_valid, out_data, out_pu, out_last, out_round,
    output out_ready
  );
endinterface

// File: rtl/patch_readout_ctrl.sv
// Reads every PU's KxK patch out of the img2col bank and streams it to the systolic array,
// one round at a time, releasing the bank with round_ack and flagging done after ROUNDS rounds.
module patch_readout_ctrl #(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int NUM_PU = 28,
  parameter int ROUNDS = 28
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  input  logic round_valid,
  output logic round_ack,
  output logic busy,
  output logic done,
  output logic [2:0] dbg_state,
  patch_readout_ctrl_if.master bus
);
  localparam int KK    = K * K;
  localparam int PU_W  = $clog2(NUM_PU);
  localparam int IDX_W = $clog2(KK);
  localparam int RND_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KK - 1);
  localparam logic [PU_W-1:0]  PU_LAST  = PU_W'(NUM_PU - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_ROUND, S_READ, S_DRAIN, S_FINISH} state_e;

  state_e            state_q, state_d;
  logic [PU_W-1:0]   pu_q, pu_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              inflight_q, inflight_d;
  logic [PU_W-1:0]   pipe_pu_q, pipe_pu_d;
  logic              pipe_last_q, pipe_last_d;

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [PU_W-1:0]   fpu_q [2];
  logic [PU_W-1:0]   fpu_d [2];
  logic              flast_q [2];
  logic              flast_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic       push, pop, rd_en;
  logic [2:0] occ;

  // Credit: FIFO entries plus the read in flight, minus the beat leaving now, must stay below 2.
  assign pop   = (count_q != 2'd0) && bus.out_ready;
  assign push  = inflight_q;
  assign occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en = (state_q == S_READ) && (occ < 3'd2);

  assign round_ack = (state_q == S_DRAIN) && (count_q == 2'd0) && !inflight_q;
  assign done      = (state_q == S_FINISH);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  assign bus.rd_en     = rd_en;
  assign bus.rd_pu     = pu_q;
  assign bus.rd_idx    = idx_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_pu    = fpu_q[rd_ptr_q];
  assign bus.out_last  = flast_q[rd_ptr_q];
  assign bus.out_round = round_q;

  always_comb begin
    state_d = state_q;
    pu_d    = pu_q;
    idx_d   = idx_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        round_d = '0;
        pu_d    = '0;
        idx_d   = '0;
        if (start) state_d = S_WAIT_ROUND;
      end
      S_WAIT_ROUND: begin
        pu_d  = '0;
        idx_d = '0;
        if (round_valid) state_d = S_READ;
      end
      S_READ: begin
        if (rd_en) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (pu_q == PU_LAST) begin
              pu_d    = '0;
              state_d = S_DRAIN;
            end else begin
              pu_d = pu_q + PU_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (round_ack) begin
          if (round_q == RND_LAST) begin
            round_d = '0;
            state_d = S_FINISH;
          end else begin
            round_d = round_q + RND_W'(1);
            state_d = S_WAIT_ROUND;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bank data lands one cycle after the strobe, so the address tag rides along in a pipe stage.
  always_comb begin
    inflight_d  = rd_en;
    pipe_pu_d   = rd_en ? pu_q : pipe_pu_q;
    pipe_last_d = rd_en ? (idx_q == IDX_LAST) : pipe_last_q;
    data_d      = data_q;
    fpu_d       = fpu_q;
    flast_d     = flast_q;
    if (push) begin
      data_d[wr_ptr_q]  = bus.rd_data;
      fpu_d[wr_ptr_q]   = pipe_pu_q;
      flast_d[wr_ptr_q] = pipe_last_q;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      pu_q        <= '0;
      idx_q       <= '0;
      round_q     <= '0;
      inflight_q  <= 1'b0;
      pipe_pu_q   <= '0;
      pipe_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        fpu_q[i]   <= '0;
        flast_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      pu_q        <= pu_d;
      idx_q       <= idx_d;
      round_q     <= round_d;
      inflight_q  <= inflight_d;
      pipe_pu_q   <= pipe_pu_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= data_d[i];
        fpu_q[i]   <= fpu_d[i];
        flast_q[i] <= flast_d[i];
      end
    end
  end
endmodule
